noc_wrr_arbiter: RTL and testbench
==================================

Name: noc_wrr_arbiter

Overview:
Parametrised weighted round-robin arbiter for NoC router output ports. It is the successor to the plain round-robin arbiter. It arbitrates NUM_AGENTS input-port requests and grants the winner up to its programmed weight of consecutive beats. A per-agent lock keeps the grant for wormhole packets until the tail. The grant is registered, one-hot, and has no bubble between back-to-back owners.

Parameters:
NUM_AGENTS, 4, number of requesting agents (≥2)
WEIGHT_W, 4, width of each per-agent weight field
IDX_W, $clog2(NUM_AGENTS), width of grant_idx (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
request  input  NUM_AGENTS  per-agent request, level
lock  input  NUM_AGENTS  per-agent packet lock (high from head flit until tail flit sent)
weight  input  NUM_AGENTS*WEIGHT_W  packed weights, agent i at [i*WEIGHT_W +: WEIGHT_W]
grant  output  NUM_AGENTS  registered one-hot grant
grant_valid  output  1  OR of grant
grant_idx  output  IDX_W  encoded owner index, 0 when grant_valid=0
beat_cnt  output  WEIGHT_W  beats served by the current owner, saturating

Behaviour:
- Reset (rst_n=0, async): grant=0, grant_valid=0, grant_idx=0, beat_cnt=0, ptr=0, state=IDLE. Reset mid-grant drops the grant immediately. No partial state survives reset.
- State machine has two states, IDLE and OWN. Internal ptr is the highest-priority index for the next search.
- Search function: first requesting agent at or after the start index, circularly. The start index itself is eligible, so a sole requester can re-win.
- IDLE: if request≠0, search from ptr. The winner's grant appears at the next edge (1-cycle latency). Set beat_cnt=1, latch eff_w=max(weight[winner],1), go to OWN. If request=0, stay in IDLE with all outputs 0.
- OWN, owner o, each cycle:
  - Beat: grant[o]&request[o] counts as a served beat.
  - Release condition: request[o]=0, OR (beat_cnt≥eff_w AND lock[o]=0).
  - No release: keep grant, beat_cnt=min(beat_cnt+1, 2^WEIGHT_W−1).
  - Release: ptr=(o+1) mod NUM_AGENTS. Search from (o+1) mod N on the current request vector.
  - Release with a winner w: grant switches to w at the next edge with no idle cycle, beat_cnt=1, eff_w re-latched from weight[w], stay in OWN.
  - Release with no winner: grant=0, beat_cnt=0, go to IDLE.
- Lock overrides weight exhaustion only. Dropping request always releases, even when lock is high.
- Weight changes while an agent owns the grant do not affect that grant. Weights are sampled only when a grant starts.
- Weight 0 is treated as 1.
- Requests from non-owners never preempt the current owner.
- grant is always one-hot or zero. grant_idx and grant_valid are consistent with grant in the same cycle.
- Request or lock bits for agents other than the owner are ignored until the next search.

Test Plan:
- Reset, then request=4'b0001 held, weights all 1 → grant=0001 one cycle after request. It re-grants agent 0 every cycle with no gap, beat_cnt=1 each cycle, grant_idx=0.
- request=4'b1111 held, weights all 1 → grant sequence 0001,0010,0100,1000,0001… with one change per cycle.
- request=4'b0011, weight0=3, weight1=1 → grant pattern 0001×3, 0010×1, repeating. beat_cnt runs 1,2,3,1,…
- request=4'b0011, weight0=1, lock[0] high for 5 cycles after its grant → agent 0 holds 5 cycles (beat_cnt 1..5), then agent 1 gets the grant the next cycle.
- Owner agent 2 drops request mid-burst with weight=4 and lock high, other requests=0 → grant=0 and grant_valid=0 at the next edge. A later request on agent 3 is granted first (ptr=3).
- rst_n pulled low during a grant to agent 1 → grant=0 asynchronously. After release, request=4'b0110 grants agent 1 first (ptr=0 search).

Source files
------------

// File: rtl/noc_wrr_arbiter.sv
// Weighted round-robin arbiter for NoC output ports.
// Registered one-hot grant, per-agent weight, wormhole lock.
module noc_wrr_arbiter #(
  parameter int NUM_AGENTS = 4,
  parameter int WEIGHT_W = 4,
  localparam int IDX_W = $clog2(NUM_AGENTS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_AGENTS-1:0]          request,
  input  logic [NUM_AGENTS-1:0]          lock,
  input  logic [NUM_AGENTS*WEIGHT_W-1:0] weight,
  output logic [NUM_AGENTS-1:0]          grant,
  output logic                           grant_valid,
  output logic [IDX_W-1:0]               grant_idx,
  output logic [WEIGHT_W-1:0]            beat_cnt
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t state, state_n;

  logic [IDX_W-1:0] owner, owner_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] nxt, start, win;
  logic             hit, rel;

  logic [WEIGHT_W-1:0] beat_n, eff_w, eff_n;
  logic [WEIGHT_W-1:0] w_arr [NUM_AGENTS];
  logic [WEIGHT_W-1:0] w_win, w_sat;

  for (genvar g = 0; g < NUM_AGENTS; g++) begin : g_w
    assign w_arr[g] = weight[g*WEIGHT_W +: WEIGHT_W];
  end

  assign nxt = (owner == IDX_W'(NUM_AGENTS-1))
             ? '0 : owner + 1'b1;

  // Owner's successor is the search origin on release.
  assign start = (state == OWN) ? nxt : ptr;

  always_comb begin
    logic [IDX_W-1:0] j;
    hit = 1'b0;
    win = '0;
    j   = '0;
    for (int i = NUM_AGENTS-1; i >= 0; i--) begin
      j = IDX_W'((int'(start) + i) % NUM_AGENTS);
      if (request[j]) begin
        hit = 1'b1;
        win = j;
      end
    end
  end

  assign w_win = w_arr[win];
  assign w_sat = (w_win == '0) ? WEIGHT_W'(1) : w_win;

  assign rel = !request[owner] ||
               ((beat_cnt >= eff_w) && !lock[owner]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
      eff_w    <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_n;
      eff_w    <= eff_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    beat_n  = beat_cnt;
    eff_n   = eff_w;
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_n = OWN;
          owner_n = win;
          beat_n  = WEIGHT_W'(1);
          eff_n   = w_sat;
        end
      end
      OWN: begin
        if (rel) begin
          ptr_n = nxt;
          if (hit) begin
            owner_n = win;
            beat_n  = WEIGHT_W'(1);
            eff_n   = w_sat;
          end else begin
            state_n = IDLE;
            owner_n = '0;
            beat_n  = '0;
          end
        end else if (beat_cnt != '1) begin
          beat_n = beat_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign grant_valid = (state == OWN);
  assign grant_idx   = grant_valid ? owner : '0;
  assign grant = grant_valid
               ? (NUM_AGENTS'(1) << owner) : '0;

endmodule

// File: tb/tb_noc_wrr_arbiter.sv
// Bench for noc_wrr_arbiter: vector table plus
// hand sequences, checked through an expectation queue.
module tb_noc_wrr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  request;
  logic [3:0]  lock;
  logic [15:0] weight;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic [3:0]  beat_cnt;

  noc_wrr_arbiter #(
    .NUM_AGENTS(4),
    .WEIGHT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .request(request),
    .lock(lock),
    .weight(weight),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx),
    .beat_cnt(beat_cnt)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  lck;
    logic [15:0] w;
    logic [3:0]  g;
    logic [3:0]  b;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [3:0] b;
    string      tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag);
    exp_t e;
    logic [1:0] ei;
    logic       ev;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e  = sb.pop_front();
    ei = 2'd0;
    for (int i = 0; i < 4; i++)
      if (e.g[i]) ei = 2'(i);
    ev = |e.g;
    n_vec++;
    if (grant !== e.g || grant_valid !== ev ||
        grant_idx !== ei || beat_cnt !== e.b) begin
      n_bad++;
      $display("FAIL %s: got g=%b v=%b i=%0d b=%0d exp g=%b v=%b i=%0d b=%0d",
               e.tag, grant, grant_valid, grant_idx, beat_cnt,
               e.g, ev, ei, e.b);
    end
  endtask

  task automatic apply(input logic [3:0] r, input logic [3:0] l,
                       input logic [15:0] w, input logic [3:0] eg,
                       input logic [3:0] eb, input string tag);
    request = r;
    lock    = l;
    weight  = w;
    sb.push_back('{eg, eb, tag});
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] l,
                     input logic [15:0] w, input logic [3:0] g,
                     input logic [3:0] b);
    tbl.push_back('{r, l, w, g, b});
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    request = '0;
    lock    = '0;
    weight  = 16'h1111;

    // idle, then sole requester re-wins each cycle
    add(4'b0000, 4'b0000, 16'h1111, 4'b0000, 4'd0);
    add(4'b0001, 4'b0000, 16'h1111, 4'b0001, 4'd1);
    add(4'b0001, 4'b0000, 16'h1111, 4'b0001, 4'd1);
    add(4'b0001, 4'b0000, 16'h1111, 4'b0001, 4'd1);
    // full rotation, one change per cycle
    add(4'b1111, 4'b0000, 16'h1111, 4'b0010, 4'd1);
    add(4'b1111, 4'b0000, 16'h1111, 4'b0100, 4'd1);
    add(4'b1111, 4'b0000, 16'h1111, 4'b1000, 4'd1);
    add(4'b1111, 4'b0000, 16'h1111, 4'b0001, 4'd1);
    add(4'b1111, 4'b0000, 16'h1111, 4'b0010, 4'd1);
    // weight0=3, weight1=1
    add(4'b0011, 4'b0000, 16'h1113, 4'b0001, 4'd1);
    add(4'b0011, 4'b0000, 16'h1113, 4'b0001, 4'd2);
    add(4'b0011, 4'b0000, 16'h1113, 4'b0001, 4'd3);
    add(4'b0011, 4'b0000, 16'h1113, 4'b0010, 4'd1);
    add(4'b0011, 4'b0000, 16'h1113, 4'b0001, 4'd1);
    add(4'b0011, 4'b0000, 16'h1113, 4'b0001, 4'd2);
    add(4'b0011, 4'b0000, 16'h1113, 4'b0001, 4'd3);
    add(4'b0011, 4'b0000, 16'h1113, 4'b0010, 4'd1);
    // lock extends agent 0 to five beats
    add(4'b0011, 4'b0000, 16'h1111, 4'b0001, 4'd1);
    add(4'b0011, 4'b0001, 16'h1111, 4'b0001, 4'd2);
    add(4'b0011, 4'b0001, 16'h1111, 4'b0001, 4'd3);
    add(4'b0011, 4'b0001, 16'h1111, 4'b0001, 4'd4);
    add(4'b0011, 4'b0001, 16'h1111, 4'b0001, 4'd5);
    add(4'b0011, 4'b0000, 16'h1111, 4'b0010, 4'd1);
    // locked owner drops request, then ptr=3
    add(4'b0100, 4'b0100, 16'h1411, 4'b0100, 4'd1);
    add(4'b0100, 4'b0100, 16'h1411, 4'b0100, 4'd2);
    add(4'b0000, 4'b0100, 16'h1411, 4'b0000, 4'd0);
    add(4'b0000, 4'b0000, 16'h1411, 4'b0000, 4'd0);
    add(4'b1001, 4'b0000, 16'h1411, 4'b1000, 4'd1);
    // weight 0 acts as 1
    add(4'b1000, 4'b0000, 16'h0411, 4'b1000, 4'd1);
    add(4'b1000, 4'b0000, 16'h0411, 4'b1000, 4'd1);
    // weight change during a grant is ignored
    add(4'b0001, 4'b0000, 16'h0412, 4'b0001, 4'd1);
    add(4'b0001, 4'b0000, 16'h0411, 4'b0001, 4'd2);
    add(4'b0001, 4'b0000, 16'h0411, 4'b0001, 4'd1);
    add(4'b0001, 4'b0000, 16'h0411, 4'b0001, 4'd1);

    repeat (2) @(posedge clk);
    #1;
    sb.push_back('{4'b0000, 4'd0, "reset"});
    compare("reset");
    rst_n = 1'b1;

    foreach (tbl[k])
      apply(tbl[k].req, tbl[k].lck, tbl[k].w,
            tbl[k].g, tbl[k].b, $sformatf("vec%0d", k));

    // beat counter saturates under a long lock
    for (int k = 0; k < 16; k++)
      apply(4'b0001, 4'b0001, 16'h0411, 4'b0001,
            4'((k + 2 > 15) ? 15 : k + 2), $sformatf("sat%0d", k));
    apply(4'b0001, 4'b0000, 16'h0411, 4'b0001, 4'd1, "sat_rel");

    // move ptr to 2 with agent 1 owning, then reset
    apply(4'b0010, 4'b0000, 16'h0411, 4'b0010, 4'd1, "pre_rst0");
    apply(4'b0010, 4'b0000, 16'h0411, 4'b0010, 4'd1, "pre_rst1");
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back('{4'b0000, 4'd0, "async_rst"});
    compare("async_rst");
    request = 4'b0110;
    @(posedge clk);
    #1;
    sb.push_back('{4'b0000, 4'd0, "in_rst"});
    compare("in_rst");
    rst_n = 1'b1;
    apply(4'b0110, 4'b0000, 16'h0411, 4'b0010, 4'd1, "post_rst0");
    apply(4'b0110, 4'b0000, 16'h0411, 4'b0100, 4'd1, "post_rst1");

    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL sb_drain: %0d left, 0 expected", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
